// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the memory-stage FSM state type,
// and opcode classification helpers.
package cpu_pkg;

   localparam int DATA_W = 16;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_LOAD  = 5'h10;
   localparam opcode_t OP_STORE = 5'h11;
   localparam opcode_t OP_BEQ   = 5'h18;
   localparam opcode_t OP_BGT   = 5'h19;
   localparam opcode_t OP_BLT   = 5'h1A;
   localparam opcode_t OP_JMP   = 5'h1B;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   function automatic logic is_mem_op(input opcode_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic is_branch_op(input opcode_t op);
      return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_BLT) || (op == OP_JMP);
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition: decides whether a branch opcode is taken
// from the Execute flags. Non-branch opcodes are never taken.
module branch_resolve
   import cpu_pkg::*;
(
   input  opcode_t opcode,
   input  logic    zf,
   input  logic    gf,
   input  logic    lf,
   output logic    taken
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = zf;
         OP_BGT:  taken = gf;
         OP_BLT:  taken = lf;
         OP_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: passes ALU/branch results to writeback in one cycle and
// runs load/store bus accesses with an ack timeout and a sticky error flag.
module memory_stage
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [4:0]        control_in,
   input  logic [4:0]        dest_index_in,
   input  logic              dest_we_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] target_in,
   input  logic              zf,
   input  logic              gf,
   input  logic              lf,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              wb_valid,
   output logic [4:0]        wb_control,
   output logic [4:0]        wb_dest_index,
   output logic              wb_we,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_timeout
);

   mem_state_t state, next_state;

   logic [3:0] wait_cnt;
   logic [4:0] wait_next;
   opcode_t    ctrl_q;
   logic [4:0] dest_q;
   logic       we_q;

   logic accept_mem, accept_other, ack_done, timed_out, taken;

   branch_resolve u_branch_resolve (
      .opcode (control_in),
      .zf     (zf),
      .gf     (gf),
      .lf     (lf),
      .taken  (taken)
   );

   // Compared one bit wider so the final increment is seen before the 4-bit counter wraps.
   assign wait_next = {1'b0, wait_cnt} + 5'd1;

   always_comb begin
      next_state   = state;
      accept_mem   = 1'b0;
      accept_other = 1'b0;
      ack_done     = 1'b0;
      timed_out    = 1'b0;
      stall        = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in) begin
               if (is_mem_op(control_in)) begin
                  accept_mem = 1'b1;
                  stall      = 1'b1;
                  next_state = ACCESS;
               end else begin
                  accept_other = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               ack_done   = 1'b1;
               next_state = IDLE;
            end else begin
               stall = 1'b1;
               if (wait_next == 5'(TIMEOUT_CYCLES)) begin
                  timed_out  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      if (reset) stall = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         wb_valid      <= 1'b0;
         wb_control    <= '0;
         wb_dest_index <= '0;
         wb_we         <= 1'b0;
         wb_data       <= '0;
         mem_timeout   <= 1'b0;
         wait_cnt      <= '0;
         ctrl_q        <= '0;
         dest_q        <= '0;
         we_q          <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         branch_taken <= 1'b0;

         if (accept_other) begin
            wb_valid      <= 1'b1;
            wb_control    <= control_in;
            wb_dest_index <= dest_index_in;
            wb_data       <= result_in;
            wb_we         <= dest_we_in && !is_branch_op(control_in);
            if (is_branch_op(control_in)) begin
               branch_taken  <= taken;
               branch_target <= target_in;
            end
         end

         if (accept_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (control_in == OP_STORE);
            mem_addr  <= result_in;
            mem_wdata <= store_data;
            ctrl_q    <= control_in;
            dest_q    <= dest_index_in;
            we_q      <= dest_we_in;
            wait_cnt  <= '0;
         end

         if (ack_done) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            wb_valid      <= 1'b1;
            wb_control    <= ctrl_q;
            wb_dest_index <= dest_q;
            if (ctrl_q == OP_LOAD) begin
               wb_data <= mem_rdata;
               wb_we   <= we_q;
            end else begin
               wb_we <= 1'b0;
            end
         end else if (timed_out) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_timeout   <= 1'b1;
            wb_valid      <= 1'b1;
            wb_control    <= ctrl_q;
            wb_dest_index <= dest_q;
            wb_we         <= 1'b0;
            wb_data       <= '0;
         end else if (state == ACCESS) begin
            wait_cnt <= wait_next[3:0];
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver predicts each retired
// instruction's writeback, a negedge monitor pops and compares on wb_valid.
module tb_memory_stage;
   import cpu_pkg::*;

   localparam int TO = 15;

   logic        clk, reset, valid_in, dest_we_in, zf, gf, lf;
   logic [4:0]  control_in, dest_index_in;
   logic [15:0] result_in, store_data, target_in, mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, stall, branch_taken, wb_valid, wb_we, mem_timeout;
   logic [15:0] mem_addr, mem_wdata, branch_target, wb_data;
   logic [4:0]  wb_control, wb_dest_index;

   memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .control_in(control_in),
      .dest_index_in(dest_index_in), .dest_we_in(dest_we_in), .result_in(result_in),
      .store_data(store_data), .target_in(target_in), .zf(zf), .gf(gf), .lf(lf),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .wb_valid(wb_valid), .wb_control(wb_control), .wb_dest_index(wb_dest_index),
      .wb_we(wb_we), .wb_data(wb_data), .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ctrl;
      logic [4:0]  dest;
      logic        we;
      logic        chk_data;
      logic [15:0] data;
      logic        bt;
      logic [15:0] btgt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic branch_ref(input logic [4:0] op, input logic z, g, l);
      case (op)
         OP_BEQ:  return z;
         OP_BGT:  return g;
         OP_BLT:  return l;
         OP_JMP:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor: every writeback pulse must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", 32'(wb_valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("wb_control", 32'(wb_control), 32'(mon_e.ctrl));
            check("wb_dest_index", 32'(wb_dest_index), 32'(mon_e.dest));
            check("wb_we", 32'(wb_we), 32'(mon_e.we));
            if (mon_e.chk_data) check("wb_data", 32'(wb_data), 32'(mon_e.data));
            check("branch_taken", 32'(branch_taken), 32'(mon_e.bt));
            if (mon_e.bt) check("branch_target", 32'(branch_target), 32'(mon_e.btgt));
         end
      end else if (reset === 1'b0) begin
         check("branch_taken_no_wb", 32'(branch_taken), 32'd0);
      end
   end

   task automatic drive(input logic [4:0] op, input logic [4:0] dest, input logic we,
                        input logic [15:0] res, input logic [15:0] sd, input logic [15:0] tgt,
                        input logic z, input logic g, input logic l);
      valid_in      = 1'b1;
      control_in    = op;
      dest_index_in = dest;
      dest_we_in    = we;
      result_in     = res;
      store_data    = sd;
      target_in     = tgt;
      zf = z; gf = g; lf = l;
   endtask

   task automatic bubble();
      valid_in = 1'b0;
      mem_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_bubble", 32'(stall), 32'd0);
      check("mem_req_bubble", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic do_other(input logic [4:0] op, input logic [4:0] dest, input logic we,
                           input logic [15:0] res, input logic [15:0] tgt,
                           input logic z, input logic g, input logic l, input logic ack_noise);
      exp_t e;
      logic is_br;
      drive(op, dest, we, res, 16'($urandom), tgt, z, g, l);
      mem_ack = ack_noise;
      is_br   = (op >= OP_BEQ) && (op <= OP_JMP);
      @(negedge clk);
      check("stall_other", 32'(stall), 32'd0);
      e.ctrl = op; e.dest = dest; e.we = we && !is_br;
      e.chk_data = 1'b1; e.data = res;
      e.bt = is_br && branch_ref(op, z, g, l); e.btgt = tgt;
      sb.push_back(e);
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   // lat = ACCESS cycle (1-based) carrying the ack; 0 or > TO means the ack never comes.
   task automatic do_mem(input bit st, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [4:0] dest, input logic we, input int lat,
                         input logic [15:0] rdata);
      exp_t e;
      bit   tmo;
      logic [4:0] op;
      op  = st ? OP_STORE : OP_LOAD;
      tmo = (lat < 1) || (lat > TO);
      drive(op, dest, we, addr, wdata, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      mem_ack = 1'b0;
      @(negedge clk);
      check("stall_accept", 32'(stall), 32'd1);
      check("mem_req_accept", 32'(mem_req), 32'd0);
      e.ctrl = op; e.dest = dest; e.we = (!st && !tmo) ? we : 1'b0;
      e.chk_data = !st && !tmo; e.data = rdata; e.bt = 1'b0; e.btgt = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      for (int k = 1; k <= TO; k++) begin
         if (k == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end else begin
            mem_rdata = 16'($urandom);
         end
         @(negedge clk);
         check("mem_req_access", 32'(mem_req), 32'd1);
         check("mem_we_access", 32'(mem_we), 32'(st));
         check("mem_addr_access", 32'(mem_addr), 32'(addr));
         if (st) check("mem_wdata_access", 32'(mem_wdata), 32'(wdata));
         check("stall_access", 32'(stall), 32'(k != lat));
         @(posedge clk); #1;
         if (k == lat) begin
            mem_ack = 1'b0;
            return;
         end
      end
      valid_in = 1'b0;
      @(negedge clk);
      check("mem_req_after_timeout", 32'(mem_req), 32'd0);
      check("mem_timeout_set", 32'(mem_timeout), 32'd1);
      check("stall_after_timeout", 32'(stall), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_branch_taken"}, 32'(branch_taken), 32'd0);
      check({tag, "_branch_target"}, 32'(branch_target), 32'd0);
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      check({tag, "_wb_control"}, 32'(wb_control), 32'd0);
      check({tag, "_wb_dest_index"}, 32'(wb_dest_index), 32'd0);
      check({tag, "_wb_we"}, 32'(wb_we), 32'd0);
      check({tag, "_wb_data"}, 32'(wb_data), 32'd0);
      check({tag, "_mem_timeout"}, 32'(mem_timeout), 32'd0);
   endtask

   task automatic random_ops(input int n);
      int kind;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 11);
         if (kind <= 4)
            do_other(5'($urandom_range(0, 15)), 5'($urandom), 1'($urandom), 16'($urandom),
                     16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         else if (kind <= 6)
            do_other(5'(OP_BEQ + 5'($urandom_range(0, 3))), 5'($urandom), 1'($urandom),
                     16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         else if (kind <= 8)
            do_mem(1'b0, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
                   $urandom_range(1, 6), 16'($urandom));
         else if (kind == 9)
            do_mem(1'b1, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
                   $urandom_range(1, 6), 16'($urandom));
         else
            bubble();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; valid_in = 1'b0; control_in = '0; dest_index_in = '0; dest_we_in = 1'b0;
      result_in = '0; store_data = '0; target_in = '0; zf = 1'b0; gf = 1'b0; lf = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      do_other(5'h03, 5'd3, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      do_mem(1'b0, 16'h0040, 16'h0000, 5'd7, 1'b1, 3, 16'hBEEF);
      do_mem(1'b1, 16'h0080, 16'h00AA, 5'd2, 1'b1, 1, 16'h0000);
      do_other(OP_BEQ, 5'd1, 1'b1, 16'h5555, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
      do_other(OP_BEQ, 5'd1, 1'b1, 16'h5555, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0);
      do_other(OP_JMP, 5'd4, 1'b1, 16'h0007, 16'h0222, 1'b0, 1'b0, 1'b0, 1'b0);
      do_other(5'h05, 5'd9, 1'b1, 16'hCAFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      bubble();

      do_mem(1'b0, 16'h0123, 16'h0000, 5'd4, 1'b1, TO, 16'h4321);
      bubble();
      check("no_timeout_ack_last_cycle", 32'(mem_timeout), 32'd0);

      do_mem(1'b0, 16'h0200, 16'h0000, 5'd5, 1'b1, 0, 16'h0000);
      random_ops(150);
      check("mem_timeout_sticky", 32'(mem_timeout), 32'd1);

      drive(OP_LOAD, 5'd6, 1'b1, 16'h0300, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      check("mem_req_before_reset", 32'(mem_req), 32'd1);
      reset    = 1'b1;
      valid_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_access_reset");
      @(posedge clk); #1;

      random_ops(30);
      repeat (3) bubble();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL expose ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL expose: valid_in  in  1  EX/MEM entry valid; control_in  in  5  opcode from Execute.
REQ-003 SHALL expose: dest_index_in  in  5; dest_we_in  in  1; result_in  in  16  ALU result/address; store_data  in  16; target_in  in  16  branch target.
REQ-004 SHALL expose: zf, gf, lf  in  1 each  Execute flags.
REQ-005 SHALL expose: mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  16; mem_rdata  in  16; mem_ack  in  1.
REQ-006 SHALL expose: stall  out  1  hold upstream; branch_taken  out  1; branch_target  out  16.
REQ-007 SHALL expose: wb_valid  out  1; wb_control  out  5; wb_dest_index  out  5; wb_we  out  1; wb_data  out  16; mem_timeout  out  1  sticky error.
REQ-008 SHALL use parameter TIMEOUT_CYCLES, default 15, max cycles waiting for mem_ack.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS.
REQ-010 IDLE, valid_in, non-memory op: SHALL register inputs into WB outputs next edge (latency 1), wb_data=result_in, wb_valid=1.
REQ-011 IDLE, valid_in, OP_LOAD/OP_STORE: SHALL latch address/data/dest, enter ACCESS, raise mem_req next cycle; stall=1 combinationally in this cycle.
REQ-012 ACCESS: mem_req=1, mem_we=1 for store only; mem_addr/mem_wdata SHALL remain stable until ack.
REQ-013 ACCESS: stall SHALL be 1 while mem_ack=0; stall=0 in the mem_ack cycle.
REQ-014 On mem_ack: SHALL return to IDLE; next edge wb_valid=1; load: wb_data=mem_rdata, wb_we=dest_we latched; store: wb_we=0.
REQ-015 mem_ack in IDLE SHALL be ignored.
REQ-016 Wait counter (4-bit) SHALL clear on ACCESS entry, increment each cycle without ack; reaching TIMEOUT_CYCLES SHALL set mem_timeout, drop mem_req, return to IDLE, emit wb_valid=1 with wb_we=0.
REQ-017 Ack arriving in same cycle as timeout SHALL take priority (normal completion, no error).
REQ-018 wb_valid SHALL be a one-cycle pulse per retired instruction; 0 on bubble (valid_in=0).
REQ-019 Branch ops SHALL resolve in IDLE on acceptance: BEQ taken if zf; BGT if gf; BLT if lf; JMP always; branch_taken registered one-cycle pulse, branch_target=target_in.
REQ-020 Branch ops SHALL produce wb_valid=1, wb_we=0.
REQ-021 All outputs SHALL be registered except stall.

Reset
REQ-022 reset SHALL force IDLE; mem_req, mem_we, wb_valid, wb_we, branch_taken, stall, mem_timeout = 0; mem_addr, mem_wdata, wb_data, branch_target = 16'h0000; wb_control, wb_dest_index = 0; counter = 0.
REQ-023 reset during ACCESS SHALL abandon the access (mem_req 0 next cycle, no wb_valid).
REQ-024 mem_timeout SHALL clear only on reset.

Structure
REQ-025 Opcode constants SHALL live in shared package cpu_pkg: OP_LOAD=5'h10, OP_STORE=5'h11, OP_BEQ=5'h18, OP_BGT=5'h19, OP_BLT=5'h1A, OP_JMP=5'h1B; FSM state enum there too.
REQ-026 Branch condition logic SHALL be sub-module branch_resolve (combinational, opcode+flags -> taken).

Verification
REQ-027 ALU op, result_in=16'h1234, dest 3, we=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_dest_index=3, stall=0.
REQ-028 LOAD addr 16'h0040, ack after 3 cycles with mem_rdata=16'hBEEF -> stall high until ack cycle, wb_data=16'hBEEF, wb_we=1.
REQ-029 STORE addr 16'h0080 data 16'h00AA, immediate ack -> mem_we=1, mem_wdata=16'h00AA, wb_we=0.
REQ-030 LOAD, ack never -> after 15 cycles mem_timeout=1, mem_req=0, wb_valid pulse with wb_we=0; ack on cycle 15 -> no timeout.
REQ-031 BEQ target 16'h0100 with zf=1 -> branch_taken pulse, branch_target=16'h0100; zf=0 -> branch_taken=0.
REQ-032 reset asserted mid-ACCESS -> all outputs at reset values next cycle, no wb_valid.
